// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control FSM for the RV32I R-type / lw / sw / beq subset.
// It sequences a shared-memory, shared-ALU datapath and counts retired instructions.
// Build option MC_ILLEGAL_TRAP_EN: when defined, an illegal instruction locks the FSM
// in TRAP until reset. When undefined, the instruction retires as a no-op and
// `illegal` pulses for one cycle.
module mc_control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       f3,
    input  logic [6:0]       f7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             rf_we,
    output logic             result_src,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_ADDR   = 4'd2,
        S_MEM_RD = 4'd3,
        S_WB_MEM = 4'd4,
        S_MEM_WR = 4'd5,
        S_EXEC_R = 4'd6,
        S_WB_ALU = 4'd7,
        S_BRANCH = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;
    logic             w_bad;
    logic             w_r_ok;
    logic [2:0]       w_r_alu;

    assign state   = r_state;
    assign instret = r_instret;

    // Decode the R-type {funct7, funct3} pair into an ALU op and a legality flag.
    always_comb begin
        w_r_ok  = 1'b1;
        w_r_alu = ALU_ADD;
        case ({f7, f3})
            {7'b0000000, 3'b000}: w_r_alu = ALU_ADD;
            {7'b0100000, 3'b000}: w_r_alu = ALU_SUB;
            {7'b0000000, 3'b111}: w_r_alu = ALU_AND;
            {7'b0000000, 3'b110}: w_r_alu = ALU_OR;
            {7'b0000000, 3'b010}: w_r_alu = ALU_SLT;
            default:              w_r_ok  = 1'b0;
        endcase
    end

    // Next-state, retire strobe and control outputs; reset forces every output low.
    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        w_bad      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        alu_src_b  = 1'b0;
        alu_ctrl   = ALU_ADD;
        rf_we      = 1'b0;
        result_src = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_R:         w_next = S_EXEC_R;
                    OP_LW, OP_SW: w_next = S_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    default:      w_bad  = 1'b1;
                endcase
            end
            S_EXEC_R: begin
                alu_ctrl = w_r_alu;
                if (w_r_ok) w_next = S_WB_ALU;
                else        w_bad  = 1'b1;
            end
            S_WB_ALU: begin
                rf_we    = 1'b1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_ADDR: begin
                alu_src_b = 1'b1;
                w_next    = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) w_next = S_WB_MEM;
            end
            S_WB_MEM: begin
                rf_we      = 1'b1;
                result_src = 1'b1;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_BRANCH: begin
                alu_ctrl = ALU_SUB;
                pc_src   = 1'b1;
                if (f3 == 3'b000) begin
                    pc_we    = zero;
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    w_bad = 1'b1;
                end
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase

        // Illegal handling is applied last so it overrides the per-state next state.
        if (w_bad) begin
            illegal = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
            w_next  = S_TRAP;
`else
            w_next   = S_FETCH;
            w_retire = 1'b1;
`endif
        end

        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            adr_src    = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            pc_src     = 1'b0;
            alu_src_b  = 1'b0;
            alu_ctrl   = ALU_ADD;
            rf_we      = 1'b0;
            result_src = 1'b0;
            illegal    = 1'b0;
        end
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: zero-wait vector table, randomized instruction stream
// against a transaction-level model, and directed reset / trap sequences.
`timescale 1ns/1ps
module tb_mc_control_fsm;

    localparam int unsigned TB_CNT_W = 4;
`ifdef MC_ILLEGAL_TRAP_EN
    localparam int unsigned N_CLS = 4;
`else
    localparam int unsigned N_CLS = 7;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [6:0]          op = '0;
    logic [2:0]          f3 = '0;
    logic [6:0]          f7 = '0;
    logic                zero = 1'b0;
    logic                mem_ready = 1'b0;
    logic                mem_req, mem_we, adr_src, ir_we, pc_we, pc_src, alu_src_b;
    logic [2:0]          alu_ctrl;
    logic                rf_we, result_src, illegal;
    logic [3:0]          state;
    logic [TB_CNT_W-1:0] instret;

    always #5 clk = ~clk;

    mc_control_fsm #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .rf_we(rf_we), .result_src(result_src), .illegal(illegal),
        .state(state), .instret(instret)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned exp_ret = 0;

    typedef struct {
        logic [6:0]  vop;
        logic [2:0]  vf3;
        logic [6:0]  vf7;
        logic        vzero;
        int unsigned len;
        logic [19:0] states;
        logic [4:0]  rf;
        logic [4:0]  pcwe;
        logic [4:0]  memwe;
        logic [4:0]  ill;
        logic        alu_chk;
        logic [2:0]  alu;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [6:0] o, input logic [2:0] a, input logic [6:0] b,
                           input logic z, input int unsigned len, input logic [19:0] st,
                           input logic [4:0] rf, input logic [4:0] pw, input logic [4:0] mw,
                           input logic [4:0] il, input logic ac, input logic [2:0] alu);
        vec_t v;
        v.vop = o; v.vf3 = a; v.vf7 = b; v.vzero = z; v.len = len; v.states = st;
        v.rf = rf; v.pcwe = pw; v.memwe = mw; v.ill = il; v.alu_chk = ac; v.alu = alu;
        tbl.push_back(v);
    endtask

    // Spec rule table for R-type: returns {legal, alu code}.
    function automatic logic [3:0] r_func(input logic [6:0] f7_i, input logic [2:0] f3_i);
        if (f7_i == 7'h00 && f3_i == 3'd0) return 4'b1000;
        if (f7_i == 7'h20 && f3_i == 3'd0) return 4'b1001;
        if (f7_i == 7'h00 && f3_i == 3'd7) return 4'b1010;
        if (f7_i == 7'h00 && f3_i == 3'd6) return 4'b1011;
        if (f7_i == 7'h00 && f3_i == 3'd2) return 4'b1101;
        return 4'b0000;
    endfunction

    // Transaction-level model: per-instruction totals derived from the instruction class.
    task automatic model(input logic [6:0] o, input logic [2:0] a, input logic [6:0] b,
                         input logic z, input int unsigned wf, input int unsigned wd,
                         output int unsigned cyc, output int unsigned rf, output int unsigned mw,
                         output int unsigned fr, output int unsigned dr, output int unsigned pw,
                         output int unsigned il, output int unsigned rs,
                         output logic [2:0] alu, output logic achk);
        logic [3:0] rr;
        fr = 1 + wf; pw = 1; cyc = 2 + wf;
        rf = 0; mw = 0; dr = 0; il = 0; rs = 0; alu = 3'b000; achk = 1'b0;
        case (o)
            7'h33: begin
                rr = r_func(b, a);
                if (rr[3]) begin cyc += 2; rf = 1; alu = rr[2:0]; achk = 1'b1; end
                else begin cyc += 1; il = 1; end
            end
            7'h03: begin cyc += 3 + wd; dr = 1 + wd; rf = 1; rs = 1; end
            7'h23: begin cyc += 2 + wd; dr = 1 + wd; mw = 1 + wd; end
            7'h63: begin
                cyc += 1;
                if (a == 3'd0) pw += (z ? 1 : 0);
                else il = 1;
            end
            default: il = 1;
        endcase
    endtask

    // Applies one zero-wait table vector, checking per-cycle behaviour.
    task automatic run_vec(input int unsigned idx, input vec_t v);
        op = v.vop; f3 = v.vf3; f7 = v.vf7; zero = v.vzero; mem_ready = 1'b1;
        for (int unsigned c = 0; c < v.len; c++) begin
            @(negedge clk);
            check($sformatf("v%0d c%0d state", idx, c), state, v.states[4*c +: 4]);
            check($sformatf("v%0d c%0d rf_we", idx, c), rf_we, v.rf[c]);
            check($sformatf("v%0d c%0d pc_we", idx, c), pc_we, v.pcwe[c]);
            check($sformatf("v%0d c%0d mem_we", idx, c), mem_we, v.memwe[c]);
            check($sformatf("v%0d c%0d illegal", idx, c), illegal, v.ill[c]);
            if (v.alu_chk && c == 2) check($sformatf("v%0d alu_ctrl", idx), alu_ctrl, v.alu);
            @(posedge clk); #1;
        end
        exp_ret++;
        check($sformatf("v%0d end state", idx), state, 0);
        check($sformatf("v%0d instret", idx), instret, exp_ret % (1 << TB_CNT_W));
    endtask

    // Runs one instruction with wf fetch waits and wd data waits, compares totals to the model.
    task automatic run_instr(input int unsigned idx, input logic [6:0] o, input logic [2:0] a,
                             input logic [6:0] b, input logic z,
                             input int unsigned wf, input int unsigned wd);
        int unsigned e_cyc, e_rf, e_mw, e_fr, e_dr, e_pw, e_il, e_rs;
        logic [2:0]  e_alu;
        logic        e_achk;
        int unsigned n = 0, rf = 0, mw = 0, fr = 0, dr = 0, pw = 0, il = 0, rs = 0;
        int unsigned rem = wf;
        bit first = 1'b1, left = 1'b0, hs;
        logic [2:0] alu_seen = 3'bxxx;
        model(o, a, b, z, wf, wd, e_cyc, e_rf, e_mw, e_fr, e_dr, e_pw, e_il, e_rs, e_alu, e_achk);
        op = o; f3 = a; f7 = b; zero = z;
        for (int unsigned c = 0; c < 100; c++) begin
            if (mem_req) begin
                if (rem > 0) begin mem_ready = 1'b0; rem--; end
                else mem_ready = 1'b1;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (mem_req && !adr_src) fr++;
            if (mem_req && adr_src) dr++;
            if (mem_we) mw++;
            if (rf_we) rf++;
            if (pc_we) pw++;
            if (illegal) il++;
            if (result_src) rs++;
            if (state == 4'd6) alu_seen = alu_ctrl;
            hs = mem_req && mem_ready;
            @(posedge clk); #1;
            n++;
            if (hs && first) begin first = 1'b0; rem = wd; end
            if (state == 4'd0 && left) break;
            if (state != 4'd0) left = 1'b1;
        end
        exp_ret++;
        check($sformatf("r%0d cycles", idx), n, e_cyc);
        check($sformatf("r%0d rf_we cycles", idx), rf, e_rf);
        check($sformatf("r%0d mem_we cycles", idx), mw, e_mw);
        check($sformatf("r%0d fetch req cycles", idx), fr, e_fr);
        check($sformatf("r%0d data req cycles", idx), dr, e_dr);
        check($sformatf("r%0d pc_we cycles", idx), pw, e_pw);
        check($sformatf("r%0d illegal cycles", idx), il, e_il);
        check($sformatf("r%0d result_src cycles", idx), rs, e_rs);
        check($sformatf("r%0d instret", idx), instret, exp_ret % (1 << TB_CNT_W));
        if (e_achk) check($sformatf("r%0d alu_ctrl", idx), alu_seen, e_alu);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned cls;
        logic [6:0] ro, rb;
        logic [2:0] ra;
        logic [3:0] sel;

        // Reset state, with mem_ready high to show enables stay forced low.
        #1 rst = 1'b1;
        mem_ready = 1'b1; zero = 1'b1; op = 7'h33;
        @(posedge clk); @(negedge clk);
        check("rst state", state, 0);
        check("rst instret", instret, 0);
        check("rst outputs", {mem_req, mem_we, adr_src, ir_we, pc_we, pc_src, alu_src_b,
                              alu_ctrl, rf_we, result_src, illegal}, 0);
        @(posedge clk); #1 rst = 1'b0;
        #1 check("first fetch req", {mem_req, adr_src}, 2'b10);

        add_vec(7'h33, 3'd0, 7'h00, 1'b0, 4, 20'h07610, 5'b01000, 5'b00001, 5'b0, 5'b0, 1'b1, 3'b000);
        add_vec(7'h33, 3'd0, 7'h20, 1'b1, 4, 20'h07610, 5'b01000, 5'b00001, 5'b0, 5'b0, 1'b1, 3'b001);
        add_vec(7'h33, 3'd7, 7'h00, 1'b0, 4, 20'h07610, 5'b01000, 5'b00001, 5'b0, 5'b0, 1'b1, 3'b010);
        add_vec(7'h33, 3'd6, 7'h00, 1'b0, 4, 20'h07610, 5'b01000, 5'b00001, 5'b0, 5'b0, 1'b1, 3'b011);
        add_vec(7'h33, 3'd2, 7'h00, 1'b0, 4, 20'h07610, 5'b01000, 5'b00001, 5'b0, 5'b0, 1'b1, 3'b101);
        add_vec(7'h03, 3'd2, 7'h00, 1'b0, 5, 20'h43210, 5'b10000, 5'b00001, 5'b0, 5'b0, 1'b1, 3'b000);
        add_vec(7'h23, 3'd2, 7'h00, 1'b0, 4, 20'h05210, 5'b00000, 5'b00001, 5'b01000, 5'b0, 1'b1, 3'b000);
        add_vec(7'h63, 3'd0, 7'h00, 1'b1, 3, 20'h00810, 5'b00000, 5'b00101, 5'b0, 5'b0, 1'b1, 3'b001);
        add_vec(7'h63, 3'd0, 7'h00, 1'b0, 3, 20'h00810, 5'b00000, 5'b00001, 5'b0, 5'b0, 1'b1, 3'b001);
`ifndef MC_ILLEGAL_TRAP_EN
        add_vec(7'h7F, 3'd0, 7'h00, 1'b0, 2, 20'h00010, 5'b00000, 5'b00001, 5'b0, 5'b00010, 1'b0, 3'b000);
        add_vec(7'h33, 3'd0, 7'h01, 1'b0, 3, 20'h00610, 5'b00000, 5'b00001, 5'b0, 5'b00100, 1'b0, 3'b000);
        add_vec(7'h63, 3'd1, 7'h00, 1'b1, 3, 20'h00810, 5'b00000, 5'b00001, 5'b0, 5'b00100, 1'b0, 3'b000);
`endif
        foreach (tbl[i]) run_vec(i, tbl[i]);

        // Directed: lw with three MEM_RD wait cycles (8 cycles total).
        run_instr(1000, 7'h03, 3'd2, 7'h00, 1'b0, 0, 3);

        // Randomized instruction stream; the counter wraps along the way.
        for (int unsigned i = 0; i < 60; i++) begin
            cls = $urandom_range(0, N_CLS - 1);
            ra = 3'($urandom); rb = 7'h00; ro = 7'h33;
            case (cls)
                0: begin
                    sel = 4'($urandom_range(0, 4));
                    rb = (sel == 1) ? 7'h20 : 7'h00;
                    case (sel)
                        0, 1:    ra = 3'd0;
                        2:       ra = 3'd7;
                        3:       ra = 3'd6;
                        default: ra = 3'd2;
                    endcase
                end
                1: ro = 7'h03;
                2: ro = 7'h23;
                3: begin ro = 7'h63; ra = 3'd0; end
                4: begin
                    ro = 7'($urandom);
                    while (ro == 7'h33 || ro == 7'h03 || ro == 7'h23 || ro == 7'h63) ro = 7'($urandom);
                end
                5: rb = 7'($urandom);
                default: begin ro = 7'h63; ra = 3'($urandom_range(1, 7)); end
            endcase
            run_instr(i, ro, ra, rb, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Directed: asynchronous reset while waiting in MEM_RD.
        op = 7'h03; f3 = 3'd2; f7 = 7'h00;
        for (int unsigned c = 0; c < 20; c++) begin
            if (state == 4'd3) break;
            mem_ready = 1'b1;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        #1 check("mem_rd wait req", {state, mem_req, adr_src}, {4'd3, 2'b11});
        #1 rst = 1'b1;
        #1 check("async rst req", mem_req, 0);
        check("async rst state", state, 0);
        check("async rst instret", instret, 0);
        exp_ret = 0;
        @(posedge clk); #1 rst = 1'b0;
        #1 check("post rst fetch", {state, mem_req, adr_src}, {4'd0, 2'b10});
        run_vec(2000, tbl[0]);

`ifdef MC_ILLEGAL_TRAP_EN
        // Directed: illegal opcode locks into TRAP with a frozen counter.
        op = 7'h7F; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int unsigned c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("trap c%0d", c), {state, illegal, mem_req, pc_we, rf_we},
                  {4'd9, 4'b1000});
            check($sformatf("trap c%0d instret", c), instret, exp_ret % (1 << TB_CNT_W));
            @(posedge clk); #1;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control state machine for the RV32I subset handled by the instruction decoder: R-type ALU ops, `lw`, `sw` and `beq`. It consumes the decoder's `op`, `f3` and `f7` fields plus the ALU zero flag and a memory ready handshake. It sequences a shared-memory, shared-ALU datapath through fetch, decode, execute, memory and writeback, and counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `op` in 7: opcode from decoder.
- `f3` in 3: funct3 from decoder.
- `f7` in 7: funct7 from decoder.
- `zero` in 1: ALU result == 0.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request, held until `mem_ready`.
- `mem_we` out 1: request is a write.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALU result register.
- `ir_we` out 1: latch instruction register and old-PC register.
- `pc_we` out 1: PC write enable.
- `pc_src` out 1: PC source; 0 = PC+4, 1 = branch target (oldPC + imm).
- `alu_src_b` out 1: ALU operand B select; 0 = rs2, 1 = imm.
- `alu_ctrl` out 3: ALU op encoding.
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 101 SLT
- `rf_we` out 1: register file write enable.
- `result_src` out 1: writeback data select; 0 = ALU result, 1 = memory data.
- `illegal` out 1: unsupported instruction detected.
- `state` out 4: current state encoding, for debug.
- `instret` out CNT_W: retired-instruction count.

## Operation
- State encodings:
  - FETCH 0
  - DECODE 1
  - ADDR 2
  - MEM_RD 3
  - WB_MEM 4
  - MEM_WR 5
  - EXEC_R 6
  - WB_ALU 7
  - BRANCH 8
  - TRAP 9
- FETCH:
  - Asserts `mem_req=1`, `adr_src=0`.
  - When `mem_ready=1`: `ir_we=1`, `pc_we=1`, `pc_src=0`, next state DECODE.
  - Otherwise stays in FETCH.
- DECODE, dispatch on `op`:
  - 0110011 → EXEC_R.
  - 0000011 or 0100011 → ADDR.
  - 1100011 → BRANCH.
  - Any other value → illegal handling (see Configuration).
- EXEC_R:
  - `alu_src_b=0`.
  - `alu_ctrl` from `{f7,f3}`:
    - 0000000/000 → ADD
    - 0100000/000 → SUB
    - 0000000/111 → AND
    - 0000000/110 → OR
    - 0000000/010 → SLT
  - Any other combination is illegal; otherwise next state WB_ALU.
- WB_ALU: `rf_we=1`, `result_src=0`, next state FETCH.
- ADDR: `alu_src_b=1`, `alu_ctrl=ADD`. Next state MEM_RD for load, MEM_WR for store.
- MEM_RD:
  - `mem_req=1`, `mem_we=0`, `adr_src=1`.
  - Advances to WB_MEM on `mem_ready`.
- WB_MEM: `rf_we=1`, `result_src=1`, next state FETCH.
- MEM_WR:
  - `mem_req=1`, `mem_we=1`, `adr_src=1`.
  - Advances to FETCH on `mem_ready`.
- BRANCH:
  - `alu_src_b=0`, `alu_ctrl=SUB`.
  - `pc_we=zero`, `pc_src=1`.
  - Next state FETCH.
  - Illegal if `f3≠000`.
- Outputs not listed for a state default to 0; `alu_ctrl` defaults to ADD.
- `instret` increments by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from:
  - WB_ALU
  - WB_MEM
  - MEM_WR (only when `mem_ready=1`)
  - BRANCH
- Handshake rules:
  - Once `mem_req` is raised, `mem_we` and `adr_src` stay stable until the `mem_ready` cycle.
  - `mem_ready` is ignored in states that do not request memory.

## Timing
- State register and `instret` update on the rising edge of `clk`.
- Control outputs are combinational from state, plus `mem_ready`/`zero` for `ir_we`, `pc_we` and the advance condition.
- While `rst=1`:
  - `state=FETCH`, `instret=0`, `illegal=0`.
  - All enables (`mem_req`, `mem_we`, `ir_we`, `pc_we`, `rf_we`) are forced 0.
  - Select outputs are 0; `alu_ctrl=000`.
- Reset asserted mid-operation drops any pending request in the same cycle. The first `mem_req` appears in the first cycle after `rst` falls.
- Latency with zero-wait memory (`mem_ready` held high):
  - R-type: 4 cycles.
  - `lw`: 5 cycles.
  - `sw`: 4 cycles.
  - `beq`: 3 cycles.
- Each wait cycle on `mem_ready` adds exactly one cycle.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - Any illegal condition moves to TRAP.
  - In TRAP, `illegal=1` and all enables are 0.
  - TRAP is left only by reset; `instret` does not increment.
- `MC_ILLEGAL_TRAP_EN` undefined:
  - TRAP is never entered.
  - On an illegal condition, `illegal` pulses 1 for one cycle and the next state is FETCH.
  - The instruction retires as a no-op: PC already advanced, `instret` increments, no `rf_we` or `mem_req`.

## Test plan
- `add x3,x1,x2` (0x002081B3), `mem_ready=1`:
  - States 0→1→6→7→0.
  - `rf_we=1` only in cycle 4, with `alu_ctrl=000`.
  - `instret=1` after the 4th edge.
- `lw` (0x0000A183) with `mem_ready` low for 3 cycles in MEM_RD:
  - `mem_req` and `adr_src=1` held steady.
  - Total 8 cycles; `rf_we`/`result_src=1` in WB_MEM.
- `beq` (0x00208463):
  - `zero=1` → `pc_we=1`, `pc_src=1` in BRANCH.
  - `zero=0` → `pc_we=0`.
  - 3 cycles; `instret` increments in both cases.
- `sw` (0x0030A023):
  - `mem_we=1` only in MEM_WR.
  - `rf_we` never asserted.
  - 4 cycles.
- Opcode 0x7F:
  - With macro: state=9, `illegal` stays 1 for 10+ cycles, `instret` frozen.
  - Without macro: 1-cycle `illegal` pulse, return to FETCH, `instret+1`.
- Assert `rst` asynchronously mid-MEM_RD:
  - `mem_req` falls the same cycle; `state=0`, `instret=0`.
  - After release, fetch restarts cleanly.
